// File: rtl/hdmi_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_pattern_pkg
// Shared types and constants for the HDMI test-pattern source: pattern
// encoding, the highest legal pattern index, the 24-bit {R,G,B} colour
// constants and the wrapping "next pattern" helper.
// -----------------------------------------------------------------------------
package hdmi_pattern_pkg;

  typedef enum logic [2:0] {
    PAT_SOLID    = 3'd0,
    PAT_BARS     = 3'd1,
    PAT_BORDER   = 3'd2,
    PAT_CHECKER  = 3'd3,
    PAT_BOX      = 3'd4,
    PAT_GRADIENT = 3'd5
  } pattern_t;

  localparam logic [2:0] PAT_LAST = 3'd5;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  // Advance to the following pattern, wrapping PAT_LAST back to 0.
  function automatic logic [2:0] pat_next(input logic [2:0] cur);
    if (cur >= PAT_LAST) begin
      return 3'd0;
    end else begin
      return cur + 3'd1;
    end
  endfunction

endpackage

// File: rtl/hdmi_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// hdmi_pattern_gen_if
// Bundle between the pixel-coordinate source (hdmi core / controller) and the
// pattern generator.
//   cx, cy       : current pixel coordinates (BIT_WIDTH)
//   sel_valid    : one-cycle strobe, load sel_pattern as pending pattern
//   sel_pattern  : requested pattern 0..5
//   next_strobe  : one-cycle strobe, pending = pending+1 (wrapping)
//   rgb          : registered {R,G,B} pixel colour
//   pattern      : pattern currently displayed
// master = coordinate/control source, slave = pattern generator.
// -----------------------------------------------------------------------------
interface hdmi_pattern_gen_if #(
  parameter int BIT_WIDTH = 12
);

  logic [BIT_WIDTH-1:0] cx;
  logic [BIT_WIDTH-1:0] cy;
  logic                 sel_valid;
  logic [2:0]           sel_pattern;
  logic                 next_strobe;
  logic [23:0]          rgb;
  logic [2:0]           pattern;

  modport master (
    output cx, cy, sel_valid, sel_pattern, next_strobe,
    input  rgb, pattern
  );

  modport slave (
    input  cx, cy, sel_valid, sel_pattern, next_strobe,
    output rgb, pattern
  );

endinterface

// File: rtl/hdmi_pattern_gen_box_mover.sv
// -----------------------------------------------------------------------------
// hdmi_pattern_box_mover
// Position/direction state of the bouncing box. On every frame-start enable
// each axis moves BOX_STEP pixels and bounces off the screen edges, clamping
// to the edge on the frame where it would overshoot.
//   clk_pixel : pixel clock
//   reset     : synchronous, active-high
//   fs        : frame-start enable (one cycle per frame)
//   box_x/y   : top-left corner of the box (registered)
// -----------------------------------------------------------------------------
module hdmi_pattern_box_mover #(
  parameter int BIT_WIDTH     = 12,
  parameter int SCREEN_WIDTH  = 1920,
  parameter int SCREEN_HEIGHT = 1080,
  parameter int BOX_SIZE      = 64,
  parameter int BOX_STEP      = 4
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic                 fs,
  output logic [BIT_WIDTH-1:0] box_x,
  output logic [BIT_WIDTH-1:0] box_y
);

  // Comparisons are done one bit wider so pos+STEP cannot wrap.
  localparam logic [BIT_WIDTH:0]   X_LIMIT = (BIT_WIDTH+1)'(SCREEN_WIDTH - BOX_SIZE);
  localparam logic [BIT_WIDTH:0]   Y_LIMIT = (BIT_WIDTH+1)'(SCREEN_HEIGHT - BOX_SIZE);
  localparam logic [BIT_WIDTH:0]   STEP_W  = (BIT_WIDTH+1)'(BOX_STEP);
  localparam logic [BIT_WIDTH-1:0] STEP_N  = BIT_WIDTH'(BOX_STEP);

  logic [BIT_WIDTH-1:0] box_x_r;
  logic [BIT_WIDTH-1:0] box_y_r;
  logic                 dir_x_r;   // 1 = moving towards larger coordinates
  logic                 dir_y_r;
  logic [BIT_WIDTH:0]   step_x_s;  // {next_dir, next_pos}
  logic [BIT_WIDTH:0]   step_y_s;

  // One axis of bounce motion; returns {next_dir, next_pos}.
  function automatic logic [BIT_WIDTH:0] bounce(
    input logic [BIT_WIDTH-1:0] pos,
    input logic                 dir_pos,
    input logic [BIT_WIDTH:0]   limit
  );
    logic [BIT_WIDTH:0] pos_w;
    pos_w = {1'b0, pos};
    if (dir_pos) begin
      if (pos_w + STEP_W >= limit) begin
        return {1'b0, limit[BIT_WIDTH-1:0]};
      end else begin
        return {1'b1, pos + STEP_N};
      end
    end else begin
      if (pos_w <= STEP_W) begin
        return {1'b1, {BIT_WIDTH{1'b0}}};
      end else begin
        return {1'b0, pos - STEP_N};
      end
    end
  endfunction

  // Next position/direction for both axes.
  always_comb begin
    step_x_s = bounce(box_x_r, dir_x_r, X_LIMIT);
    step_y_s = bounce(box_y_r, dir_y_r, Y_LIMIT);
  end

  // Box state registers, advanced once per frame.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      box_x_r <= {BIT_WIDTH{1'b0}};
      box_y_r <= {BIT_WIDTH{1'b0}};
      dir_x_r <= 1'b1;
      dir_y_r <= 1'b1;
    end else if (fs) begin
      box_x_r <= step_x_s[BIT_WIDTH-1:0];
      dir_x_r <= step_x_s[BIT_WIDTH];
      box_y_r <= step_y_s[BIT_WIDTH-1:0];
      dir_y_r <= step_y_s[BIT_WIDTH];
    end
  end

  assign box_x = box_x_r;
  assign box_y = box_y_r;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// -----------------------------------------------------------------------------
// hdmi_pattern_gen
// Video test-pattern source in the pixel clock domain. Takes the hdmi core's
// cx/cy and returns registered 24-bit RGB (1 cycle latency) for one of six
// patterns: solid, colour bars, border, checkerboard, bouncing box, gradient.
// Pattern changes are held as "pending" and applied at frame start (0,0);
// the (0,0) pixel itself already uses the pending pattern.
//   clk_pixel : pixel clock
//   reset     : synchronous, active-high
//   vid       : hdmi_pattern_gen_if.slave (cx, cy, sel_valid, sel_pattern,
//               next_strobe in; rgb, pattern out)
// Optional build macro HDMI_PATTERN_AUTO_CYCLE_EN: advance the pending pattern
// automatically every AUTO_FRAMES frames; user strobes restart the count.
// -----------------------------------------------------------------------------
module hdmi_pattern_gen
  import hdmi_pattern_pkg::*;
#(
  parameter int         BIT_WIDTH       = 12,
  parameter int         SCREEN_WIDTH    = 1920,
  parameter int         SCREEN_HEIGHT   = 1080,
  parameter logic [2:0] DEFAULT_PATTERN = 3'd1,
  parameter int         BOX_SIZE        = 64,
  parameter int         BOX_STEP        = 4,
  parameter int         CHECK_LOG2      = 5,
  parameter int         AUTO_FRAMES     = 120
) (
  input  logic               clk_pixel,
  input  logic               reset,
  hdmi_pattern_gen_if.slave  vid
);

  // Elaboration-time sanity check of the configuration.
  if (AUTO_FRAMES < 1 || SCREEN_WIDTH >= (1 << BIT_WIDTH) ||
      CHECK_LOG2 >= BIT_WIDTH || BIT_WIDTH < 8) begin : g_bad_cfg
    $error("hdmi_pattern_gen: unsupported parameter combination");
  end

  // Colour-bar thresholds, fixed at elaboration so no divider is built.
  localparam logic [BIT_WIDTH-1:0] BAR_T1 = BIT_WIDTH'(1 * SCREEN_WIDTH / 8);
  localparam logic [BIT_WIDTH-1:0] BAR_T2 = BIT_WIDTH'(2 * SCREEN_WIDTH / 8);
  localparam logic [BIT_WIDTH-1:0] BAR_T3 = BIT_WIDTH'(3 * SCREEN_WIDTH / 8);
  localparam logic [BIT_WIDTH-1:0] BAR_T4 = BIT_WIDTH'(4 * SCREEN_WIDTH / 8);
  localparam logic [BIT_WIDTH-1:0] BAR_T5 = BIT_WIDTH'(5 * SCREEN_WIDTH / 8);
  localparam logic [BIT_WIDTH-1:0] BAR_T6 = BIT_WIDTH'(6 * SCREEN_WIDTH / 8);
  localparam logic [BIT_WIDTH-1:0] BAR_T7 = BIT_WIDTH'(7 * SCREEN_WIDTH / 8);
  localparam logic [BIT_WIDTH-1:0] X_LAST = BIT_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [BIT_WIDTH-1:0] Y_LAST = BIT_WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic [BIT_WIDTH-1:0] X_END  = BIT_WIDTH'(SCREEN_WIDTH);
  localparam logic [BIT_WIDTH-1:0] Y_END  = BIT_WIDTH'(SCREEN_HEIGHT);
  localparam logic [BIT_WIDTH:0]   BOX_W  = (BIT_WIDTH+1)'(BOX_SIZE);
  localparam logic [BIT_WIDTH-1:0] GREY_MAX = BIT_WIDTH'(255);

  logic [2:0]           pattern_r;
  logic [2:0]           pending_r;
  logic [2:0]           pending_nxt_s;
  logic [23:0]          rgb_r;
  logic [23:0]          pix_s;
  logic [23:0]          rgb_nxt_s;
  logic [2:0]           eff_pat_s;
  logic                 fs_s;
  logic                 active_s;
  logic                 box_hit_s;
  logic [BIT_WIDTH-1:0] box_x_s;
  logic [BIT_WIDTH-1:0] box_y_s;
  logic [BIT_WIDTH-1:0] grad_s;
  logic [7:0]           grey_s;

  assign fs_s      = (vid.cx == {BIT_WIDTH{1'b0}}) && (vid.cy == {BIT_WIDTH{1'b0}});
  assign active_s  = (vid.cx < X_END) && (vid.cy < Y_END);
  // The frame-start pixel already shows the pattern being switched in.
  assign eff_pat_s = fs_s ? pending_r : pattern_r;
  assign grad_s    = vid.cx >> 2'd3;
  assign grey_s    = (grad_s > GREY_MAX) ? 8'hFF : grad_s[7:0];
  assign box_hit_s = ({1'b0, vid.cx} >= {1'b0, box_x_s}) &&
                     ({1'b0, vid.cx} <  ({1'b0, box_x_s} + BOX_W)) &&
                     ({1'b0, vid.cy} >= {1'b0, box_y_s}) &&
                     ({1'b0, vid.cy} <  ({1'b0, box_y_s} + BOX_W));

  hdmi_pattern_box_mover #(
    .BIT_WIDTH     (BIT_WIDTH),
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT),
    .BOX_SIZE      (BOX_SIZE),
    .BOX_STEP      (BOX_STEP)
  ) u_box_mover (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .fs        (fs_s),
    .box_x     (box_x_s),
    .box_y     (box_y_s)
  );

  // Pattern pixel mux; blanking forces black.
  always_comb begin
    pix_s = COL_BLACK;
    case (pattern_t'(eff_pat_s))
      PAT_SOLID: pix_s = COL_WHITE;
      PAT_BARS: begin
        if      (vid.cx < BAR_T1) pix_s = COL_WHITE;
        else if (vid.cx < BAR_T2) pix_s = COL_YELLOW;
        else if (vid.cx < BAR_T3) pix_s = COL_CYAN;
        else if (vid.cx < BAR_T4) pix_s = COL_GREEN;
        else if (vid.cx < BAR_T5) pix_s = COL_MAGENTA;
        else if (vid.cx < BAR_T6) pix_s = COL_RED;
        else if (vid.cx < BAR_T7) pix_s = COL_BLUE;
        else                      pix_s = COL_BLACK;
      end
      PAT_BORDER: begin
        if (vid.cx == {BIT_WIDTH{1'b0}})                pix_s = COL_RED;
        else if (vid.cy == {BIT_WIDTH{1'b0}})           pix_s = COL_GREEN;
        else if ((vid.cx == X_LAST) || (vid.cy == Y_LAST)) pix_s = COL_BLUE;
        else                                            pix_s = COL_BLACK;
      end
      PAT_CHECKER: pix_s = (vid.cx[CHECK_LOG2] ^ vid.cy[CHECK_LOG2]) ? COL_WHITE : COL_BLACK;
      PAT_BOX:      pix_s = box_hit_s ? COL_WHITE : COL_BLACK;
      PAT_GRADIENT: pix_s = {grey_s, grey_s, grey_s};
      default:      pix_s = COL_BLACK;
    endcase
    rgb_nxt_s = active_s ? pix_s : COL_BLACK;
  end

`ifdef HDMI_PATTERN_AUTO_CYCLE_EN
  localparam int CNT_W = ($clog2(AUTO_FRAMES) > 8) ? $clog2(AUTO_FRAMES) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_FRAMES - 1);

  logic [CNT_W-1:0] frame_cnt_r;
  logic [CNT_W-1:0] frame_cnt_nxt_s;
  logic             user_req_s;
  logic             auto_adv_s;

  assign user_req_s = vid.sel_valid || vid.next_strobe;
  assign auto_adv_s = fs_s && (frame_cnt_r == CNT_LAST);

  // Frame counter: user requests restart it, otherwise it wraps each period.
  always_comb begin
    frame_cnt_nxt_s = frame_cnt_r;
    if (user_req_s) begin
      frame_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (auto_adv_s) begin
      frame_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (fs_s) begin
      frame_cnt_nxt_s = frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      frame_cnt_nxt_s = frame_cnt_r;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      frame_cnt_r <= {CNT_W{1'b0}};
    end else begin
      frame_cnt_r <= frame_cnt_nxt_s;
    end
  end
`else
  logic auto_adv_s;
  assign auto_adv_s = 1'b0;
`endif

  // Pending pattern: sel_valid beats next_strobe; out-of-range selects ignored.
  always_comb begin
    pending_nxt_s = pending_r;
    if (vid.sel_valid) begin
      if (vid.sel_pattern <= PAT_LAST) begin
        pending_nxt_s = vid.sel_pattern;
      end else begin
        pending_nxt_s = pending_r;
      end
    end else if (vid.next_strobe || auto_adv_s) begin
      pending_nxt_s = pat_next(pending_r);
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Output and pattern registers; displayed pattern only changes at frame start.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rgb_r     <= COL_BLACK;
      pattern_r <= DEFAULT_PATTERN;
      pending_r <= DEFAULT_PATTERN;
    end else begin
      rgb_r     <= rgb_nxt_s;
      pending_r <= pending_nxt_s;
      if (fs_s) begin
        pattern_r <= pending_r;
      end
    end
  end

  assign vid.rgb     = rgb_r;
  assign vid.pattern = pattern_r;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_hdmi_pattern_gen
// Self-checking bench: directed pixels from the test plan plus randomized
// coordinates/strobes, compared against a behavioural model of the patterns,
// pending/displayed pattern and bouncing box. Frames are advanced by driving
// the (0,0) coordinate, so no full raster scan is needed.
// -----------------------------------------------------------------------------
module tb_hdmi_pattern_gen;

  localparam int W  = 1920;
  localparam int H  = 1080;
  localparam int HT = 2200;
  localparam int VT = 1125;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  // behavioural model state
  int m_cur, m_pend, m_bx, m_by;
  bit m_dx, m_dy;

  hdmi_pattern_gen_if #(.BIT_WIDTH(12)) vif ();

  hdmi_pattern_gen dut (
    .clk_pixel (clk),
    .reset     (reset),
    .vid       (vif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input int pat, input int x, input int y);
    logic [7:0] g;
    if (x >= W || y >= H) return 24'h000000;
    case (pat)
      0: return 24'hFFFFFF;
      1: case (x * 8 / W)
           0: return 24'hFFFFFF;
           1: return 24'hFFFF00;
           2: return 24'h00FFFF;
           3: return 24'h00FF00;
           4: return 24'hFF00FF;
           5: return 24'hFF0000;
           6: return 24'h0000FF;
           default: return 24'h000000;
         endcase
      2: begin
        if (x == 0) return 24'hFF0000;
        if (y == 0) return 24'h00FF00;
        if (x == W - 1 || y == H - 1) return 24'h0000FF;
        return 24'h000000;
      end
      3: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      4: return (x >= m_bx && x < m_bx + 64 && y >= m_by && y < m_by + 64) ?
                24'hFFFFFF : 24'h000000;
      5: begin
        g = 8'((x / 8 > 255) ? 255 : x / 8);
        return {g, g, g};
      end
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_reset();
    m_cur = 1; m_pend = 1; m_bx = 0; m_by = 0; m_dx = 1'b1; m_dy = 1'b1;
  endtask

  task automatic model_frame_box();
    if (m_dx) begin
      if (m_bx + 4 >= W - 64) begin m_bx = W - 64; m_dx = 1'b0; end
      else m_bx += 4;
    end else begin
      if (m_bx <= 4) begin m_bx = 0; m_dx = 1'b1; end
      else m_bx -= 4;
    end
    if (m_dy) begin
      if (m_by + 4 >= H - 64) begin m_by = H - 64; m_dy = 1'b0; end
      else m_by += 4;
    end else begin
      if (m_by <= 4) begin m_by = 0; m_dy = 1'b1; end
      else m_by -= 4;
    end
  endtask

  // One pixel cycle: drive, let the edge pass, compare against the model.
  task automatic pix(input string tag, input int x, input int y,
                     input bit sv, input int sp, input bit ns);
    bit fs;
    vif.cx = 12'(x); vif.cy = 12'(y);
    vif.sel_valid = sv; vif.sel_pattern = 3'(sp); vif.next_strobe = ns;
    @(posedge clk); #1;
    fs = (x == 0 && y == 0);
    check({tag, "_rgb"}, vif.rgb, ref_pixel(fs ? m_pend : m_cur, x, y));
    if (fs) begin
      m_cur = m_pend;
      model_frame_box();
    end
    if (sv) begin
      if (sp <= 5) m_pend = sp;
    end else if (ns) begin
      m_pend = (m_pend + 1) % 6;
    end
    check({tag, "_pat"}, {21'd0, vif.pattern}, 24'(m_cur));
    vif.sel_valid = 1'b0; vif.next_strobe = 1'b0;
  endtask

  task automatic do_reset(input int x, input int y);
    reset = 1'b1;
    vif.cx = 12'(x); vif.cy = 12'(y);
    vif.sel_valid = 1'b0; vif.next_strobe = 1'b0; vif.sel_pattern = 3'd0;
    @(posedge clk); #1;
    model_reset();
    check("reset_rgb", vif.rgb, 24'h000000);
    check("reset_pat", {21'd0, vif.pattern}, 24'd1);
    reset = 1'b0;
  endtask

  initial begin
    int x, y;
    reset = 1'b1;
    vif.cx = 12'd0; vif.cy = 12'd0;
    vif.sel_valid = 1'b0; vif.sel_pattern = 3'd0; vif.next_strobe = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset(700, 300);

    // default pattern: colour bars
    pix("fs0", 0, 0, 0, 0, 0);
    pix("bar0", 0, 5, 0, 0, 0);
    pix("bar1", 240, 5, 0, 0, 0);
    pix("bar7", 1919, 5, 0, 0, 0);
    pix("blank", 1920, 5, 0, 0, 0);
    pix("blank2", HT - 1, VT - 1, 0, 0, 0);
    pix("bar_last_px", 239, 900, 0, 0, 0);

    // deferred switch to border
    pix("sel2", 100, 500, 1, 2, 0);
    pix("hold1", 480, 501, 0, 0, 0);
    pix("hold2", 1000, 900, 0, 0, 0);
    pix("brd00", 0, 0, 0, 0, 0);
    pix("brd50", 5, 0, 0, 0, 0);
    pix("brd_r", 1919, 7, 0, 0, 0);
    pix("brd_b", 400, 1079, 0, 0, 0);
    pix("brd55", 5, 5, 0, 0, 0);

    // sel_valid beats next_strobe; out-of-range select ignored
    pix("sel3ns", 10, 10, 1, 3, 1);
    pix("sel6", 11, 10, 1, 6, 0);
    pix("chk00", 0, 0, 0, 0, 0);
    pix("chk320", 32, 0, 0, 0, 0);
    pix("chk3232", 32, 32, 0, 0, 0);

    // two next strobes in one frame advance by two (3 -> 5)
    pix("ns_a", 50, 50, 0, 0, 1);
    pix("ns_b", 60, 50, 0, 0, 1);
    pix("grd00", 0, 0, 0, 0, 0);
    pix("grd16", 16, 0, 0, 0, 0);
    pix("grd1919", 1919, 0, 0, 0, 0);
    // wrap 5 -> 0
    pix("ns_wrap", 70, 70, 0, 0, 1);
    pix("sol00", 0, 0, 0, 0, 0);
    pix("sol", 1234, 777, 0, 0, 0);

    // bouncing box over 500 frames from a fresh reset
    do_reset(900, 400);
    pix("sel4", 100, 100, 1, 4, 0);
    for (int f = 1; f <= 500; f++) begin
      pix("box_fs", 0, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
        int ox, oy;
        case (k)
          0: begin ox = m_bx;      oy = m_by;      end
          1: begin ox = m_bx + 63; oy = m_by + 63; end
          2: begin ox = m_bx + 64; oy = m_by;      end
          3: begin ox = m_bx - 1;  oy = m_by + 10; end
          4: begin ox = m_bx + 5;  oy = m_by + 64; end
          default: begin ox = $urandom_range(0, HT - 1); oy = $urandom_range(1, VT - 1); end
        endcase
        if (ox < 0) ox = HT - 1;
        if (oy == 0 && ox == 0) oy = 1;
        pix("box", ox, oy, 0, 0, 0);
      end
    end

    // randomized coordinates and strobes
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        x = 0; y = 0;
      end else begin
        x = $urandom_range(0, HT - 1);
        y = $urandom_range(0, VT - 1);
      end
      if (i == 1500) do_reset(x, y);
      pix("rnd", x, y, $urandom_range(0, 19) == 0, $urandom_range(0, 7),
          $urandom_range(0, 14) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
